// File: rtl/dbg_module.sv
// Debug Module register target: dmcontrol/dmstatus/abstractcs/command/data0/data1
// and the abstract GPR-access handshake toward the core.
module dbg_module #(
  parameter int NGPR = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmi_valid,
  input  logic        dmi_wr,
  input  logic [6:0]  dmi_addr,
  input  logic [31:0] dmi_wdata,
  output logic [31:0] dmi_rdata,
  output logic        dbg_halt_req,
  output logic        dbg_resume_req,
  output logic        ndmreset,
  input  logic        core_halted,
  output logic        dbg_reg_req,
  output logic        dbg_reg_we,
  output logic [4:0]  dbg_reg_addr,
  output logic [31:0] dbg_reg_wdata,
  input  logic        dbg_reg_ack,
  input  logic [31:0] dbg_reg_rdata
);

  localparam logic [6:0] A_DATA0 = 7'h04;
  localparam logic [6:0] A_DATA1 = 7'h05;
  localparam logic [6:0] A_DMCTL = 7'h10;
  localparam logic [6:0] A_DMSTS = 7'h11;
  localparam logic [6:0] A_ACS   = 7'h16;
  localparam logic [6:0] A_CMD   = 7'h17;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_BUSY = 3'd1;
  localparam logic [2:0] ERR_NSUP = 3'd2;
  localparam logic [2:0] ERR_HALT = 3'd4;

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        dmactive_q;
  logic        haltreq_q;
  logic        ndmreset_q;
  logic        pending_q;
  logic        resumeack_q;
  logic [2:0]  cmderr_q;
  logic [31:0] data0_q;
  logic [31:0] data1_q;
  logic        reg_we_q;
  logic [4:0]  reg_addr_q;
  logic [31:0] reg_wdata_q;
  logic [31:0] rdata_q;

  logic        wr;
  logic        rd;
  logic        wr_d0;
  logic        wr_d1;
  logic        wr_ctl;
  logic        wr_acs;
  logic        wr_cmd;
  logic        in_req;
  logic        busy;
  logic        busy_err;
  logic [31:0] regno_ext;
  logic        cmd_legal;
  logic        cmd_xfer;
  logic        cmd_eval;
  logic        cmd_start;
  logic        ctl_clear;
  logic        resume_wr;
  logic [31:0] rd_mux;

  assign wr     = dmi_valid & dmi_wr;
  assign rd     = dmi_valid & ~dmi_wr;
  assign wr_d0  = wr && (dmi_addr == A_DATA0);
  assign wr_d1  = wr && (dmi_addr == A_DATA1);
  assign wr_ctl = wr && (dmi_addr == A_DMCTL);
  assign wr_acs = wr && (dmi_addr == A_ACS);
  assign wr_cmd = wr && (dmi_addr == A_CMD);

  // An orphaned request after deactivation is not visible as busy
  assign in_req = (state_q == S_REQ);
  assign busy   = in_req & dmactive_q;

  assign busy_err = busy &&
    (wr_cmd || wr_acs || wr_d0 || wr_d1 ||
     (rd && (dmi_addr == A_DATA0)));

  assign regno_ext = {16'd0, dmi_wdata[15:0]};
  assign cmd_legal = (dmi_wdata[31:24] == 8'd0) &&
                     (dmi_wdata[22:20] == 3'd2) &&
                     (regno_ext >= 32'h1000) &&
                     (regno_ext < 32'h1000 + 32'(NGPR));
  assign cmd_xfer  = dmi_wdata[17];

  // Commands are only evaluated with no sticky error pending
  assign cmd_eval  = wr_cmd && dmactive_q && !in_req &&
                     (cmderr_q == ERR_NONE);
  assign cmd_start = cmd_eval && cmd_legal && cmd_xfer && core_halted;

  assign ctl_clear = wr_ctl && !dmi_wdata[0];
  assign resume_wr = wr_ctl && dmi_wdata[30] && !dmi_wdata[31];

  assign dbg_halt_req   = haltreq_q;
  assign dbg_resume_req = pending_q;
  assign ndmreset       = ndmreset_q;
  assign dbg_reg_req    = in_req;
  assign dbg_reg_we     = reg_we_q;
  assign dbg_reg_addr   = reg_addr_q;
  assign dbg_reg_wdata  = reg_wdata_q;
  assign dmi_rdata      = rdata_q;

  // Register read multiplexer
  always_comb begin
    rd_mux = 32'd0;
    case (dmi_addr)
      A_DATA0: rd_mux = data0_q;
      A_DATA1: rd_mux = data1_q;
      A_DMCTL: rd_mux = {haltreq_q, 29'd0, ndmreset_q, dmactive_q};
      A_DMSTS: rd_mux = {14'd0, resumeack_q, resumeack_q, 4'd0,
                         !core_halted, !core_halted,
                         core_halted, core_halted,
                         1'b1, 3'd0, 4'd2};
      A_ACS:   rd_mux = {3'd0, 5'd0, 11'd0, busy, 1'b0,
                         cmderr_q, 4'd0, 4'd2};
      default: rd_mux = 32'd0;
    endcase
  end

  // Abstract command FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_start) state_d = S_REQ;
      S_REQ:  if (dbg_reg_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Abstract command FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Handshake payload, latched at command start and held during REQ
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_we_q    <= 1'b0;
      reg_addr_q  <= 5'd0;
      reg_wdata_q <= 32'd0;
    end else if (cmd_start) begin
      reg_we_q    <= dmi_wdata[16];
      reg_addr_q  <= dmi_wdata[4:0];
      reg_wdata_q <= data0_q;
    end
  end

  // Read data capture, held until the next read
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   rdata_q <= 32'd0;
    else if (rd) rdata_q <= rd_mux;
  end

  // Debug register state: control, resume tracking, errors, data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmactive_q  <= 1'b0;
      haltreq_q   <= 1'b0;
      ndmreset_q  <= 1'b0;
      pending_q   <= 1'b0;
      resumeack_q <= 1'b0;
      cmderr_q    <= ERR_NONE;
      data0_q     <= 32'd0;
      data1_q     <= 32'd0;
    end else if (ctl_clear) begin
      dmactive_q  <= 1'b0;
      haltreq_q   <= 1'b0;
      ndmreset_q  <= 1'b0;
      pending_q   <= 1'b0;
      resumeack_q <= 1'b0;
      cmderr_q    <= ERR_NONE;
      data0_q     <= 32'd0;
      data1_q     <= 32'd0;
    end else begin
      if (wr_ctl) begin
        dmactive_q <= 1'b1;
        haltreq_q  <= dmi_wdata[31];
        ndmreset_q <= dmi_wdata[1];
      end
      if (resume_wr) begin
        pending_q   <= 1'b1;
        resumeack_q <= 1'b0;
      end else if (pending_q && !core_halted) begin
        pending_q   <= 1'b0;
        resumeack_q <= 1'b1;
      end
      if (dmactive_q) begin
        if (busy) begin
          if (busy_err && (cmderr_q == ERR_NONE))
            cmderr_q <= ERR_BUSY;
        end else if (wr_acs) begin
          cmderr_q <= cmderr_q & ~dmi_wdata[10:8];
        end else if (cmd_eval && !cmd_legal) begin
          cmderr_q <= ERR_NSUP;
        end else if (cmd_eval && cmd_xfer && !core_halted) begin
          cmderr_q <= ERR_HALT;
        end
        if (in_req && dbg_reg_ack && !reg_we_q)
          data0_q <= dbg_reg_rdata;
        else if (!busy && wr_d0)
          data0_q <= dmi_wdata;
        if (!busy && wr_d1)
          data1_q <= dmi_wdata;
      end
    end
  end

endmodule

// File: tb/tb_dbg_module.sv
// Directed bench for dbg_module: register map, halt/resume,
// abstract GPR access, error handling, deactivation and reset.
module tb_dbg_module;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmi_valid;
  logic        dmi_wr;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata;
  logic        dbg_halt_req;
  logic        dbg_resume_req;
  logic        ndmreset;
  logic        core_halted;
  logic        dbg_reg_req;
  logic        dbg_reg_we;
  logic [4:0]  dbg_reg_addr;
  logic [31:0] dbg_reg_wdata;
  logic        dbg_reg_ack;
  logic [31:0] dbg_reg_rdata;

  int total = 0;
  int bad   = 0;

  dbg_module #(.NGPR(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .dmi_valid     (dmi_valid),
    .dmi_wr        (dmi_wr),
    .dmi_addr      (dmi_addr),
    .dmi_wdata     (dmi_wdata),
    .dmi_rdata     (dmi_rdata),
    .dbg_halt_req  (dbg_halt_req),
    .dbg_resume_req(dbg_resume_req),
    .ndmreset      (ndmreset),
    .core_halted   (core_halted),
    .dbg_reg_req   (dbg_reg_req),
    .dbg_reg_we    (dbg_reg_we),
    .dbg_reg_addr  (dbg_reg_addr),
    .dbg_reg_wdata (dbg_reg_wdata),
    .dbg_reg_ack   (dbg_reg_ack),
    .dbg_reg_rdata (dbg_reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dwr(input logic [6:0] a, input logic [31:0] d);
    dmi_valid = 1'b1;
    dmi_wr    = 1'b1;
    dmi_addr  = a;
    dmi_wdata = d;
    @(negedge clk);
    dmi_valid = 1'b0;
    dmi_wr    = 1'b0;
  endtask

  task automatic drd(input logic [6:0] a, input logic [31:0] exp,
                     input string tag);
    dmi_valid = 1'b1;
    dmi_wr    = 1'b0;
    dmi_addr  = a;
    @(negedge clk);
    dmi_valid = 1'b0;
    chk(tag, dmi_rdata, exp);
  endtask

  task automatic ack(input logic [31:0] d);
    dbg_reg_ack   = 1'b1;
    dbg_reg_rdata = d;
    @(negedge clk);
    dbg_reg_ack   = 1'b0;
    dbg_reg_rdata = 32'd0;
  endtask

  initial begin
    reset = 1'b1;
    dmi_valid = 1'b0;
    dmi_wr = 1'b0;
    dmi_addr = 7'd0;
    dmi_wdata = 32'd0;
    core_halted = 1'b0;
    dbg_reg_ack = 1'b0;
    dbg_reg_rdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_rdata", dmi_rdata, 32'd0);
    chk("rst_halt", {31'd0, dbg_halt_req}, 32'd0);
    chk("rst_resume", {31'd0, dbg_resume_req}, 32'd0);
    chk("rst_ndm", {31'd0, ndmreset}, 32'd0);
    chk("rst_req", {31'd0, dbg_reg_req}, 32'd0);
    chk("rst_we", {31'd0, dbg_reg_we}, 32'd0);
    chk("rst_addr", {27'd0, dbg_reg_addr}, 32'd0);
    chk("rst_wdata", dbg_reg_wdata, 32'd0);

    drd(7'h11, 32'h0000_0C82, "dmstatus_run");
    drd(7'h16, 32'h0000_0002, "acs_reset");
    drd(7'h3F, 32'h0000_0000, "unmapped");

    dwr(7'h10, 32'h8000_0001);
    chk("halt_req", {31'd0, dbg_halt_req}, 32'd1);
    drd(7'h10, 32'h8000_0001, "dmctl_rd");

    core_halted = 1'b1;
    dwr(7'h10, 32'h4000_0001);
    chk("resume_req", {31'd0, dbg_resume_req}, 32'd1);
    chk("halt_drop", {31'd0, dbg_halt_req}, 32'd0);
    drd(7'h10, 32'h0000_0001, "resumereq_rd0");
    drd(7'h11, 32'h0000_0382, "dmstatus_halt");
    core_halted = 1'b0;
    @(negedge clk);
    chk("resume_done", {31'd0, dbg_resume_req}, 32'd0);
    drd(7'h11, 32'h0003_0C82, "dmstatus_ack");

    core_halted = 1'b1;
    dwr(7'h04, 32'hDEAD_BEEF);
    dwr(7'h17, 32'h0023_100A);
    chk("gw_req", {31'd0, dbg_reg_req}, 32'd1);
    chk("gw_we", {31'd0, dbg_reg_we}, 32'd1);
    chk("gw_addr", {27'd0, dbg_reg_addr}, 32'd10);
    chk("gw_wdata", dbg_reg_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    @(negedge clk);
    chk("gw_hold", {31'd0, dbg_reg_req}, 32'd1);
    ack(32'h0);
    chk("gw_done", {31'd0, dbg_reg_req}, 32'd0);
    drd(7'h16, 32'h0000_0002, "gw_idle");
    drd(7'h04, 32'hDEAD_BEEF, "gw_data0");

    dwr(7'h17, 32'h0022_1005);
    chk("gr_req", {31'd0, dbg_reg_req}, 32'd1);
    chk("gr_we", {31'd0, dbg_reg_we}, 32'd0);
    chk("gr_addr", {27'd0, dbg_reg_addr}, 32'd5);
    ack(32'h1234_5678);
    chk("gr_1cyc", {31'd0, dbg_reg_req}, 32'd0);
    drd(7'h04, 32'h1234_5678, "gr_data0");

    core_halted = 1'b0;
    dwr(7'h17, 32'h0022_1005);
    chk("err4_noreq", {31'd0, dbg_reg_req}, 32'd0);
    drd(7'h16, 32'h0000_0402, "err4");
    core_halted = 1'b1;
    dwr(7'h17, 32'h0022_1005);
    chk("err_ignore", {31'd0, dbg_reg_req}, 32'd0);
    drd(7'h16, 32'h0000_0402, "err4_sticky");
    dwr(7'h16, 32'h0000_0700);
    drd(7'h16, 32'h0000_0002, "err_w1c");
    dwr(7'h17, 32'h0032_1005);
    chk("err2_noreq", {31'd0, dbg_reg_req}, 32'd0);
    drd(7'h16, 32'h0000_0202, "err2");
    dwr(7'h16, 32'h0000_0700);
    dwr(7'h17, 32'h0022_1025);
    drd(7'h16, 32'h0000_0202, "err2_regno");
    dwr(7'h16, 32'h0000_0700);

    dwr(7'h17, 32'h0023_100A);
    chk("be_wdata", dbg_reg_wdata, 32'h1234_5678);
    dwr(7'h04, 32'hAAAA_5555);
    drd(7'h16, 32'h0000_1102, "be_busy");
    ack(32'h0);
    drd(7'h04, 32'h1234_5678, "be_data0");
    drd(7'h16, 32'h0000_0102, "be_err1");
    dwr(7'h16, 32'h0000_0700);

    dwr(7'h05, 32'h0000_0055);
    drd(7'h05, 32'h0000_0055, "data1");
    dwr(7'h17, 32'h0022_1005);
    dwr(7'h10, 32'h0000_0000);
    chk("da_req", {31'd0, dbg_reg_req}, 32'd1);
    drd(7'h10, 32'h0000_0000, "da_dmctl");
    drd(7'h04, 32'h0000_0000, "da_data0");
    drd(7'h05, 32'h0000_0000, "da_data1");
    drd(7'h16, 32'h0000_0002, "da_acs");
    chk("da_wait", {31'd0, dbg_reg_req}, 32'd1);
    ack(32'h9999_9999);
    chk("da_idle", {31'd0, dbg_reg_req}, 32'd0);
    drd(7'h04, 32'h0000_0000, "da_discard");

    dwr(7'h10, 32'h0000_0001);
    dwr(7'h17, 32'h0022_1005);
    chk("ar_req", {31'd0, dbg_reg_req}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_drop", {31'd0, dbg_reg_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drd(7'h10, 32'h0000_0000, "ar_dmctl");
    drd(7'h16, 32'h0000_0002, "ar_acs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
